// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode codes, FSM
// state encoding and the default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 32;

  // ALU control codes.
  localparam logic [3:0] OP_ADD      = 4'd1;
  localparam logic [3:0] OP_SUB      = 4'd2;
  localparam logic [3:0] OP_MUL      = 4'd3;
  localparam logic [3:0] OP_MOD      = 4'd4;
  localparam logic [3:0] OP_PASSATOC = 4'd5;
  localparam logic [3:0] OP_PASSBTOC = 4'd6;
  localparam logic [3:0] OP_INCAC    = 4'd7;
  localparam logic [3:0] OP_DECAC    = 4'd8;
  localparam logic [3:0] OP_RESET    = 4'd9;
  localparam logic [3:0] OP_MAX      = OP_RESET;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping upward. Purely combinational; the pointer register lives in
// the parent. Latency: 0 cycles. Backpressure: none (caller qualifies).
// Ports: req (request vector), ptr (search start), gnt (one-hot grant),
//        gnt_idx (grant index), any_gnt (at least one request present).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_idx,
  output logic               any_gnt
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencing front end for the ALU: round-robin accepts one request at a
// time, issues it to the ALU, waits its fixed latency and returns the
// result on a valid/ready response channel.
// Latency: accept edge T -> alu_en at T+1 -> rsp_valid from T+ALU_LAT+2;
//          illegal (and locally resolved) ops respond from T+1.
// Backpressure: a stalled response holds DONE; no request is accepted
//          until the response handshakes.
// Optional macro ALU_SEQ_BYPASS_EN: resolve PASSATOC/PASSBTOC/RESET locally
// without pulsing alu_en.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_op/req_a/
//        req_b request side; rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_zero/
//        rsp_err response side; alu_a/alu_b/alu_ctrl/alu_en/alu_c ALU side.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [3:0]                alu_ctrl,
  output logic                      alu_en,
  input  logic [DATA_W-1:0]         alu_c
);

  // Counter only has to hold ALU_LAT-1.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t             state, state_nxt;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gnt_idx;
  logic               any_gnt;

  logic [3:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [1:0]         id_q;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data_q;
  logic               zero_q, err_q;

  logic [3:0]         op_sel;
  logic [DATA_W-1:0]  a_sel, b_sel;
  logic               sel_legal;
  logic               sel_local;
  logic [DATA_W-1:0]  local_dat;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign op_sel    = req_op[int'(gnt_idx)*4 +: 4];
  assign a_sel     = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign b_sel     = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_legal = op_is_legal(op_sel);

`ifdef ALU_SEQ_BYPASS_EN
  // Pass-through and clear ops need no ALU round trip.
  always_comb begin
    sel_local = 1'b0;
    local_dat = '0;
    case (op_sel)
      OP_PASSATOC: begin sel_local = 1'b1; local_dat = a_sel; end
      OP_PASSBTOC: begin sel_local = 1'b1; local_dat = b_sel; end
      OP_RESET:    begin sel_local = 1'b1; local_dat = '0;    end
      default:     ;
    endcase
  end
`else
  assign sel_local = 1'b0;
  assign local_dat = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    alu_en    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = gnt;
        if (any_gnt) state_nxt = (!sel_legal || sel_local) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_en    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      cnt    <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_gnt) begin
            op_q <= op_sel;
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= gnt_idx;
            ptr  <= (gnt_idx == 2'(NUM_REQ-1)) ? 2'd0 : gnt_idx + 2'd1;
            if (!sel_legal) begin
              data_q <= '0;
              zero_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (sel_local) begin
              data_q <= local_dat;
              zero_q <= (local_dat == '0);
              err_q  <= 1'b0;
            end
          end
        end
        ST_ISSUE: cnt <= CNT_W'(ALU_LAT-1);
        ST_WAIT: begin
          // cnt==0 is exactly the cycle alu_c carries this op's result.
          if (cnt == '0) begin
            data_q <= alu_c;
            zero_q <= (alu_c == '0);
            err_q  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;
  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a fixed-latency ALU model.
// Latency: ALU model presents results ALU_LAT cycles after alu_en.
// Backpressure: rsp_ready driven by the bench, stalled in one scenario.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int ALU_LAT = 4;
`ifdef ALU_SEQ_BYPASS_EN
  localparam int BYP_LAT = 1;
  localparam int BYP_EN  = 0;
`else
  localparam int BYP_LAT = ALU_LAT + 2;
  localparam int BYP_EN  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_ctrl;
  logic        alu_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(32), .NUM_REQ(2), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
    .alu_c(alu_c)
  );

  // ALU model: result appears on alu_c only in the cycle ALU_LAT after alu_en.
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      OP_ADD:      return a + b;
      OP_SUB:      return a - b;
      OP_MUL:      return a * b;
      OP_MOD:      return (b == 0) ? 32'd0 : a % b;
      OP_PASSATOC: return a;
      OP_PASSBTOC: return b;
      OP_INCAC:    return a + 1;
      OP_DECAC:    return a - 1;
      default:     return 32'd0;
    endcase
  endfunction

  logic [31:0] pd [ALU_LAT];
  logic        pv [ALU_LAT] = '{default: 1'b0};
  always @(posedge clk) begin
    pv[0] <= alu_en;
    pd[0] <= alu_f(alu_ctrl, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign alu_c = pv[ALU_LAT-1] ? pd[ALU_LAT-1] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*r +: 4] = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  // Called just after a negedge. Issues one op from requester r and follows
  // it to the response handshake; ends one cycle after the handshake.
  task automatic run_op(input string tag, input int r, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_err,
                        input int exp_lat, input int exp_en, input int stall,
                        input int pend, output int waited);
    int en_cnt;
    int lat;
    set_req(r, op, a, b);
    req_valid[r] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[r] && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, "_acc"}, req_ready[r], 1);
    rsp_ready = (stall == 0);
    en_cnt = 0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[r] = 1'b0;
        if (pend >= 0) begin
          set_req(pend, OP_ADD, 32'd1, 32'd2);
          req_valid[pend] = 1'b1;
        end
      end
      #1;
      if (alu_en) en_cnt++;
      if (rsp_valid) lat = k;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_en"}, en_cnt, exp_en);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_id"}, rsp_id, r);
    check({tag, "_zero"}, rsp_zero, exp_d == 0);
    check({tag, "_err"}, rsp_err, exp_err);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk); #1;
      check({tag, "_stall_vld"}, rsp_valid, 1);
      check({tag, "_stall_data"}, {rsp_zero, rsp_err, rsp_data}, {exp_d == 0, exp_err, exp_d});
      check({tag, "_stall_rdy"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check({tag, "_rsp_clr"}, rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [3:0]  b_op [6] = '{OP_ADD, OP_SUB, OP_INCAC, OP_MUL, OP_DECAC, OP_MOD};
  logic [31:0] b_a  [6] = '{32'd10, 32'd10, 32'd4, 32'd3, 32'd8, 32'd17};
  logic [31:0] b_b  [6] = '{32'd1, 32'd3, 32'd0, 32'd4, 32'd0, 32'd5};
  int          e_ord [6] = '{0, 1, 0, 1, 0, 1};
  logic [31:0] e_dat [6] = '{32'd11, 32'd12, 32'd7, 32'd7, 32'd5, 32'd2};

  initial begin
    int w;
    int nrsp, nacc, ra;
    int idx [2];
    bit upd [2];
    int acc [8];
    logic [1:0]  rid  [8];
    logic [31:0] rdat [8];

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ctl", {rsp_valid, alu_en, rsp_zero, rsp_err, rsp_id, req_ready}, 0);
    check("reset_dat", {alu_a, alu_b, alu_ctrl, rsp_data}, 0);

    run_op("add", 0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, ALU_LAT+2, 1, 0, -1, w);
    run_op("illegal", 1, 4'hF, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0, 0, -1, w);
    run_op("sub_stall", 1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b0, ALU_LAT+2, 1, 5, 0, w);
    // req0 was left pending during the stall and must go in right away.
    run_op("pend", 0, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, ALU_LAT+2, 1, 0, -1, w);
    check("pend_wait", w, 0);
    run_op("passb", 0, OP_PASSBTOC, 32'd1, 32'hDEAD, 32'hDEAD, 1'b0, BYP_LAT, BYP_EN, 0, -1, w);

    // Reset in the middle of WAIT drops the op.
    set_req(0, OP_ADD, 32'd1, 32'd1);
    req_valid[0] = 1'b1;
    #1;
    check("rstw_acc", req_ready[0], 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
    end
    #1;
    rst = 1'b1;
    #1;
    check("rstw_ctl", {rsp_valid, alu_en, rsp_zero, rsp_err, rsp_id, req_ready}, 0);
    check("rstw_dat", {alu_a, alu_b, alu_ctrl, rsp_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) w++;
    end
    check("rstw_norsp", w, 0);
    run_op("mul", 1, OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, ALU_LAT+2, 1, 0, -1, w);

    // Both requesters continuously valid: strict alternation from pointer 0.
    do_reset();
    nrsp = 0;
    nacc = 0;
    for (int r = 0; r < 2; r++) begin
      idx[r] = 0;
      upd[r] = 1'b0;
      set_req(r, b_op[r*3], b_a[r*3], b_b[r*3]);
    end
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 200 && nrsp < 6; c++) begin
      if (c > 0) begin
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
          if (upd[r]) begin
            upd[r] = 1'b0;
            idx[r]++;
            if (idx[r] < 3) set_req(r, b_op[r*3+idx[r]], b_a[r*3+idx[r]], b_b[r*3+idx[r]]);
            else req_valid[r] = 1'b0;
          end
        end
        #1;
      end
      if (rsp_valid) begin
        rid[nrsp]  = rsp_id;
        rdat[nrsp] = rsp_data;
        nrsp++;
      end
      if (req_ready != 0 && nacc < 8) begin
        ra = req_ready[1] ? 1 : 0;
        acc[nacc] = ra;
        nacc++;
        upd[ra] = 1'b1;
      end
    end
    check("b2b_nrsp", nrsp, 6);
    check("b2b_nacc", nacc, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < nacc) check($sformatf("b2b_acc%0d", i), acc[i], e_ord[i]);
      if (i < nrsp) begin
        check($sformatf("b2b_id%0d", i), rid[i], e_ord[i]);
        check($sformatf("b2b_dat%0d", i), rdat[i], e_dat[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
